// File: rtl/dp_rr_scheduler_if.sv
// Bundle of requester, datapath and response signals for dp_rr_scheduler.
// The slave modport is the scheduler's view of the bundle; the master modport is the clients' view.
interface dp_rr_scheduler_if #(
    parameter int WIDTH    = 8,
    parameter int NR_REQ   = 4,
    parameter int ID_WIDTH = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
);
    logic [NR_REQ-1:0]       req_valid_i;
    logic [NR_REQ*WIDTH-1:0] req_data_i;
    logic [NR_REQ-1:0]       req_ready_o;
    logic                    dp_start_o;
    logic [WIDTH-1:0]        dp_data_o;
    logic [WIDTH-1:0]        dp_data_i;
    logic                    rsp_valid_o;
    logic [WIDTH-1:0]        rsp_data_o;
    logic [ID_WIDTH-1:0]     rsp_id_o;
    logic                    rsp_ready_i;
    logic                    busy_o;

    modport slave (
        input  req_valid_i, req_data_i, dp_data_i, rsp_ready_i,
        output req_ready_o, dp_start_o, dp_data_o, rsp_valid_o, rsp_data_o, rsp_id_o, busy_o
    );

    modport master (
        output req_valid_i, req_data_i, dp_data_i, rsp_ready_i,
        input  req_ready_o, dp_start_o, dp_data_o, rsp_valid_o, rsp_data_o, rsp_id_o, busy_o
    );
endinterface

// File: rtl/dp_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency datapath between NR_REQ requesters.
// One transaction is in flight at a time; results come back tagged with the requester ID.
module dp_rr_scheduler #(
    parameter int WIDTH   = 8,
    parameter int NR_REQ  = 4,
    parameter int LATENCY = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dp_rr_scheduler_if.slave bus
);
    localparam int ID_WIDTH  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int CNT_WIDTH = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   ptr_q;
    logic [ID_WIDTH-1:0]   winner;
    logic                  found;
    logic                  grant;
    logic [CNT_WIDTH-1:0]  cnt_q;

    // Search from the priority pointer upward, wrapping, for the first valid requester.
    always_comb begin
        int                  idx;
        logic [ID_WIDTH-1:0] cand;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int k = 0; k < NR_REQ; k++) begin
            idx  = (int'(ptr_q) + k) % NR_REQ;
            cand = ID_WIDTH'(idx);
            if (!found && bus.req_valid_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign grant = (state_q == IDLE) && found;

    // The grant is masked while reset is held so no requester sees an accept during reset.
    always_comb begin
        bus.req_ready_o = '0;
        if (grant && !rst_i) begin
            bus.req_ready_o[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = BUSY;
            BUSY:    if (cnt_q == '0) state_d = RESP;
            RESP:    if (bus.rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q           <= '0;
            cnt_q           <= '0;
            bus.dp_start_o  <= 1'b0;
            bus.dp_data_o   <= '0;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_data_o  <= '0;
            bus.rsp_id_o    <= '0;
        end else begin
            bus.dp_start_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        bus.dp_data_o  <= bus.req_data_i[int'(winner)*WIDTH +: WIDTH];
                        bus.dp_start_o <= 1'b1;
                        bus.rsp_id_o   <= winner;
                        cnt_q          <= CNT_WIDTH'(LATENCY);
                        ptr_q          <= (winner == ID_WIDTH'(NR_REQ - 1)) ? '0
                                          : winner + ID_WIDTH'(1);
                    end
                end
                BUSY: begin
                    // The counter reaches zero exactly when the datapath result is valid.
                    if (cnt_q == '0) begin
                        bus.rsp_data_o  <= bus.dp_data_i;
                        bus.rsp_valid_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        bus.rsp_valid_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o = (state_q != IDLE);
endmodule

// File: tb/tb_dp_rr_scheduler.sv
// Testbench for dp_rr_scheduler: directed grant sequences with a response scoreboard
// and a datapath model that returns operand+1 only in the cycle the result is due.
module tb_dp_rr_scheduler;
    localparam int WIDTH    = 8;
    localparam int NR_REQ   = 4;
    localparam int LATENCY  = 2;
    localparam int ID_WIDTH = 2;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [WIDTH-1:0]    data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dp_rr_scheduler_if #(.WIDTH(WIDTH), .NR_REQ(NR_REQ), .ID_WIDTH(ID_WIDTH)) bus ();

    dp_rr_scheduler #(.WIDTH(WIDTH), .NR_REQ(NR_REQ), .LATENCY(LATENCY)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    rsp_t             exp_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               n_rsp    = 0;
    logic [WIDTH-1:0] lane_op [NR_REQ];
    int               dp_cnt;
    logic [WIDTH-1:0] dp_op;

    // Datapath model: the result is only meaningful in the cycle it is due, garbage otherwise.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_cnt <= 0;
            dp_op  <= '0;
        end else if (bus.dp_start_o) begin
            dp_cnt <= LATENCY;
            dp_op  <= bus.dp_data_o;
        end else if (dp_cnt > 0) begin
            dp_cnt <= dp_cnt - 1;
        end
    end

    assign bus.dp_data_i = (dp_cnt == 1) ? dp_op + 8'h01 : 8'hEE;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic setLane(input int n, input logic [WIDTH-1:0] val);
        lane_op[n] = val;
        bus.req_data_i[n*WIDTH +: WIDTH] = val;
    endtask

    task automatic pushExpected(input int n);
        rsp_t e;
        e.id   = ID_WIDTH'(n);
        e.data = lane_op[n] + 8'h01;
        exp_q.push_back(e);
    endtask

    task automatic doReset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // One full transaction with rsp_ready high: grant cycle, granted requester drops, wait out BUSY.
    task automatic applyStimulus(input logic [NR_REQ-1:0] mask, input logic [NR_REQ-1:0] exp_ready,
                                 input string tag);
        @(posedge clk); #1;
        bus.req_valid_i = mask;
        for (int n = 0; n < NR_REQ; n++) begin
            if (exp_ready[n]) pushExpected(n);
        end
        @(negedge clk);
        checkOutput(tag, bus.req_ready_o, exp_ready);
        @(posedge clk); #1;
        bus.req_valid_i = mask & ~exp_ready;
        repeat (3) @(posedge clk);
    endtask

    // Scoreboard: every response handshake must match the oldest expected entry.
    always @(negedge clk) begin
        rsp_t e;
        if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_rsp_id", bus.rsp_id_o, e.id);
                checkOutput("sb_rsp_data", bus.rsp_data_o, e.data);
            end
        end
    end

    initial begin
        logic [NR_REQ-1:0] exp_grant;
        int                rsp_before;

        rst             = 1'b1;
        bus.req_valid_i = 4'b1111;
        bus.req_data_i  = '0;
        bus.rsp_ready_i = 1'b1;
        setLane(0, 8'h13);
        setLane(1, 8'h27);
        setLane(2, 8'h5A);
        setLane(3, 8'hC4);

        // Reset values, with all requesters asserting to exercise the masked grant.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", bus.req_ready_o, 4'b0000);
        checkOutput("rst_dp_start", bus.dp_start_o, 1'b0);
        checkOutput("rst_dp_data", bus.dp_data_o, 8'h00);
        checkOutput("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        checkOutput("rst_rsp_data", bus.rsp_data_o, 8'h00);
        checkOutput("rst_rsp_id", bus.rsp_id_o, 2'd0);
        checkOutput("rst_busy", bus.busy_o, 1'b0);
        bus.req_valid_i = '0;
        @(posedge clk); #1 rst = 1'b0;

        // Single request from requester 2.
        @(posedge clk); #1;
        bus.req_valid_i = 4'b0100;
        pushExpected(2);
        @(negedge clk);
        checkOutput("t1_ready", bus.req_ready_o, 4'b0100);
        checkOutput("t1_busy0", bus.busy_o, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 1) bus.req_valid_i = '0;
            @(negedge clk);
            checkOutput("t1_dp_start", bus.dp_start_o, (c == 1));
            checkOutput("t1_rsp_valid", bus.rsp_valid_o, (c == 4));
            if (c == 1) checkOutput("t1_dp_data", bus.dp_data_o, 8'h5A);
            if (c == 4) begin
                checkOutput("t1_rsp_data", bus.rsp_data_o, 8'h5B);
                checkOutput("t1_rsp_id", bus.rsp_id_o, 2'd2);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t1_idle", bus.busy_o, 1'b0);

        // All four requesters continuously valid: grants 0,1,2,3,0,1 spaced five cycles.
        doReset();
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (c == 0) bus.req_valid_i = 4'b1111;
            exp_grant = '0;
            if (c % 5 == 0) begin
                exp_grant[(c/5) % 4] = 1'b1;
                pushExpected((c/5) % 4);
            end
            @(negedge clk);
            checkOutput("t2_grant", bus.req_ready_o, exp_grant);
        end
        @(posedge clk); #1;
        bus.req_valid_i = '0;

        // Backpressure: response held six cycles while requester 3 waits.
        bus.rsp_ready_i = 1'b0;
        @(posedge clk); #1;
        bus.req_valid_i = 4'b0010;
        pushExpected(1);
        @(negedge clk);
        checkOutput("t3_ready", bus.req_ready_o, 4'b0010);
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            if (c == 1) bus.req_valid_i = '0;
            if (c == 4) bus.req_valid_i = 4'b1000;
            if (c == 10) begin
                bus.req_valid_i = '0;
                bus.rsp_ready_i = 1'b1;
            end
            @(negedge clk);
            if (c >= 4 && c <= 9) begin
                checkOutput("t3_hold_valid", bus.rsp_valid_o, 1'b1);
                checkOutput("t3_hold_data", bus.rsp_data_o, 8'h28);
                checkOutput("t3_hold_id", bus.rsp_id_o, 2'd1);
                checkOutput("t3_hold_ready", bus.req_ready_o, 4'b0000);
                checkOutput("t3_hold_busy", bus.busy_o, 1'b1);
            end
            if (c == 11) begin
                checkOutput("t3_idle_busy", bus.busy_o, 1'b0);
                checkOutput("t3_idle_valid", bus.rsp_valid_o, 1'b0);
            end
        end

        // Pointer wrap after serving requester 3.
        applyStimulus(4'b1000, 4'b1000, "t4_grant3");
        applyStimulus(4'b1010, 4'b0010, "t4_wrap1");
        applyStimulus(4'b1000, 4'b1000, "t4_next3");

        // Asynchronous reset in the issue cycle aborts the transaction and clears the pointer.
        @(posedge clk); #1;
        bus.req_valid_i = 4'b0010;
        @(negedge clk);
        checkOutput("t5_ready", bus.req_ready_o, 4'b0010);
        @(posedge clk); #1;
        bus.req_valid_i = 4'b0101;
        #1 rst = 1'b1;
        #1;
        checkOutput("t5_dp_start", bus.dp_start_o, 1'b0);
        checkOutput("t5_dp_data", bus.dp_data_o, 8'h00);
        checkOutput("t5_rsp_valid", bus.rsp_valid_o, 1'b0);
        checkOutput("t5_rsp_data", bus.rsp_data_o, 8'h00);
        checkOutput("t5_rsp_id", bus.rsp_id_o, 2'd0);
        checkOutput("t5_busy", bus.busy_o, 1'b0);
        checkOutput("t5_req_ready", bus.req_ready_o, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b0;
        pushExpected(0);
        @(negedge clk);
        checkOutput("t5_regrant", bus.req_ready_o, 4'b0001);
        @(posedge clk); #1;
        bus.req_valid_i = '0;
        repeat (5) @(posedge clk);

        // Requester 1 asserts only while requester 0 is being served and is never granted.
        rsp_before = n_rsp;
        @(posedge clk); #1;
        bus.req_valid_i = 4'b0001;
        pushExpected(0);
        @(negedge clk);
        checkOutput("t6_ready", bus.req_ready_o, 4'b0001);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) bus.req_valid_i = 4'b0010;
            if (c == 4) bus.req_valid_i = '0;
            @(negedge clk);
            checkOutput("t6_no_grant", bus.req_ready_o, 4'b0000);
        end
        checkOutput("t6_rsp_count", n_rsp - rsp_before, 1);

        checkOutput("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
